alu_nibble_seq: RTL and testbench

- Nibble-serial sequencer that sits directly upstream and downstream of the team's 4-bit 74181-style ALU slice (a, b, cin, s, m -> f, cout, eqv).
- Accepts W-bit operands over a valid/ready handshake and feeds the ALU one nibble per cycle, LSB nibble first, chaining the carry between nibbles.
- Collects the f nibbles into a W-bit result and presents it with the final carry and an aggregate equality flag on a second valid/ready handshake.
- Lets the existing 4-bit ALU perform 16-bit operations without replicating slices.

---
 rtl/alu_nibble_seq_pkg.sv | 20 ++
 rtl/alu_nibble_seq.sv | 131 +++++++++++++
 tb/tb_alu_nibble_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
// Select constants match the active-high 74181 function table.
package alu_nibble_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam logic [3:0] SEL_ADD = 4'b1001;
  localparam logic       M_ADD   = 1'b0;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic       M_SUB   = 1'b0;
  localparam logic [3:0] SEL_XOR = 4'b0110;
  localparam logic       M_XOR   = 1'b1;

endpackage

// File: rtl/alu_nibble_seq.sv
// Nibble-serial sequencer: feeds a 4-bit ALU slice LSB nibble first,
// chains the carry and assembles a W-bit result.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [3:0]   op_s,
  input  logic         op_m,
  input  logic         op_cin,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [3:0]   alu_s,
  output logic         alu_m,
  output logic         alu_cin,
  input  logic [3:0]   alu_f,
  input  logic         alu_cout,
  input  logic         alu_eqv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         res_cout,
  output logic         res_eqv
);

  localparam int CW = 3;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  seq_state_e    state_q, state_d;
  logic [W-1:0]  a_q, b_q, res_q;
  logic [3:0]    s_q;
  logic          m_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q;
  logic          eqv_q;
  logic          accept;
  logic          last;

  assign accept = in_valid & in_ready;
  assign last   = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    res_cout  = 1'b0;
    res_eqv   = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        alu_a   = a_q[4*cnt_q +: 4];
        alu_b   = b_q[4*cnt_q +: 4];
        alu_cin = carry_q;
      end
      DONE: begin
        out_valid = 1'b1;
        res_cout  = carry_q;
        res_eqv   = eqv_q;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign alu_s = s_q;
  assign alu_m = m_q;
  assign res   = res_q;

  // Operands are only sampled on accept; op_* is ignored while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      eqv_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            s_q     <= op_s;
            m_q     <= op_m;
            cnt_q   <= '0;
            carry_q <= op_cin;
            eqv_q   <= 1'b1;
          end
        end
        RUN: begin
          res_q[4*cnt_q +: 4] <= alu_f;
          carry_q             <= alu_cout;
          eqv_q               <= eqv_q & alu_eqv;
          if (!last) cnt_q <= cnt_q + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq with an active-high 74181 slice
// model answering the alu_* port combinationally.
module tb_alu_nibble_seq;
  import alu_nibble_seq_pkg::*;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [3:0]   op_s = '0;
  logic         op_m = 1'b0;
  logic         op_cin = 1'b0;
  logic [3:0]   alu_a, alu_b, alu_s;
  logic         alu_m, alu_cin;
  logic [3:0]   alu_f;
  logic         alu_cout, alu_eqv;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] res;
  logic         res_cout, res_eqv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s),
    .op_m(op_m), .op_cin(op_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_eqv(alu_eqv),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_cout(res_cout), .res_eqv(res_eqv)
  );

  // Active-high 74181: carry in/out are active-low.
  logic [4:0] sum;
  always_comb begin
    sum      = '0;
    alu_f    = '0;
    alu_cout = 1'b1;
    if (!alu_m) begin
      case (alu_s)
        4'b1001: sum = {1'b0, alu_a} + {1'b0, alu_b}
                       + {4'b0, ~alu_cin};
        4'b0110: sum = {1'b0, alu_a} + {1'b0, ~alu_b}
                       + {4'b0, ~alu_cin};
        default: sum = '0;
      endcase
      alu_f    = sum[3:0];
      alu_cout = ~sum[4];
    end else begin
      case (alu_s)
        4'b0110: alu_f = alu_a ^ alu_b;
        default: alu_f = '0;
      endcase
    end
  end
  assign alu_eqv = (alu_f == 4'hF);

  task automatic issue(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [3:0] s,
                       input logic m,
                       input logic cin,
                       output bit to);
    logic acc;
    to = 1'b1;
    in_valid = 1'b1;
    op_a = a; op_b = b; op_s = s;
    op_m = m; op_cin = cin;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        to = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit to);
    lat = 0;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b exp 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b exp 0", out_valid);
    end
    checks++;
    if ({res, res_cout, res_eqv} !== '0) begin
      errors++;
      $display("FAIL reset_res: got %h/%b/%b exp 0",
               res, res_cout, res_eqv);
    end
    checks++;
    if ({alu_a, alu_b, alu_s, alu_m, alu_cin} !== '0) begin
      errors++;
      $display("FAIL reset_alu: got %h %h %h %b %b exp 0",
               alu_a, alu_b, alu_s, alu_m, alu_cin);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    bit to1, to2;
    int lat;
    out_ready = 1'b1;
    issue(16'h1234, 16'h0FCF, SEL_ADD, M_ADD, 1'b1, to1);
    wait_done(lat, to2);
    checks++;
    if (to1 || to2) begin
      errors++;
      $display("FAIL add_timeout: got %b%b exp 00", to1, to2);
    end
    checks++;
    if (lat !== N) begin
      errors++;
      $display("FAIL add_latency: got %0d exp %0d", lat, N);
    end
    checks++;
    if (res !== 16'h2203 || res_cout !== 1'b1) begin
      errors++;
      $display("FAIL add_res: got %h/%b exp 2203/1",
               res, res_cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_carry;
    bit to1, to2;
    int lat;
    issue(16'hFFFF, 16'h0001, SEL_ADD, M_ADD, 1'b1, to1);
    wait_done(lat, to2);
    checks++;
    if (to1 || to2 || res !== 16'h0000 || res_cout !== 1'b0) begin
      errors++;
      $display("FAIL carry_res: got %h/%b to=%b%b exp 0000/0",
               res, res_cout, to1, to2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_eqv;
    bit to1, to2;
    int lat;
    issue(16'h5A5A, 16'h5A5A, SEL_SUB, M_SUB, 1'b1, to1);
    wait_done(lat, to2);
    checks++;
    if (to1 || to2 || res !== 16'hFFFF || res_eqv !== 1'b1) begin
      errors++;
      $display("FAIL eqv_equal: got %h/%b exp FFFF/1",
               res, res_eqv);
    end
    @(posedge clk); #1;
    issue(16'h5A5A, 16'h5A5B, SEL_SUB, M_SUB, 1'b1, to1);
    wait_done(lat, to2);
    checks++;
    if (to1 || to2 || res !== 16'hFFFE || res_eqv !== 1'b0) begin
      errors++;
      $display("FAIL eqv_diff: got %h/%b exp FFFE/0",
               res, res_eqv);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_xor_backpressure;
    bit to1, to2;
    int lat;
    int bad;
    out_ready = 1'b0;
    issue(16'hF0F0, 16'hFF00, SEL_XOR, M_XOR, 1'b0, to1);
    wait_done(lat, to2);
    checks++;
    if (to1 || to2 || res !== 16'h0FF0) begin
      errors++;
      $display("FAIL xor_res: got %h exp 0FF0", res);
    end
    checks++;
    if (alu_s !== SEL_XOR || alu_m !== 1'b1 || alu_a !== 4'h0) begin
      errors++;
      $display("FAIL xor_alu_hold: got s=%h m=%b a=%h exp 6/1/0",
               alu_s, alu_m, alu_a);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (res !== 16'h0FF0 || out_valid !== 1'b1
          || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d bad cycles exp 0", bad);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b exp 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    bit to1, to2;
    int lat;
    issue(16'h1234, 16'h0FCF, SEL_ADD, M_ADD, 1'b1, to1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (to1 || out_valid !== 1'b0 || in_ready !== 1'b1
        || res !== '0) begin
      errors++;
      $display("FAIL rst_mid: got vld=%b rdy=%b res=%h exp 0/1/0",
               out_valid, in_ready, res);
    end
    checks++;
    if ({alu_a, alu_b, alu_s, alu_m, alu_cin} !== '0) begin
      errors++;
      $display("FAIL rst_mid_alu: got %h %h %h exp 0",
               alu_a, alu_b, alu_s);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(16'h1234, 16'h0FCF, SEL_ADD, M_ADD, 1'b1, to1);
    wait_done(lat, to2);
    checks++;
    if (to1 || to2 || lat !== N || res !== 16'h2203
        || res_cout !== 1'b1) begin
      errors++;
      $display("FAIL rst_redo: got %h/%b lat=%0d exp 2203/1/%0d",
               res, res_cout, lat, N);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int acc_cyc[2];
    logic [W-1:0] r[2];
    logic c[2];
    int na, nr, cyc;
    logic acc;
    na = 0; nr = 0; cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    op_a = 16'h1234; op_b = 16'h0FCF;
    op_s = SEL_ADD; op_m = M_ADD; op_cin = 1'b1;
    while (nr < 2 && cyc < 60) begin
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        acc_cyc[na] = cyc;
        na++;
        if (na == 1) begin
          op_a = 16'hFFFF; op_b = 16'h0001;
        end else begin
          in_valid = 1'b0;
          op_a = 16'hAAAA; op_b = 16'h5555;
          op_s = SEL_XOR; op_m = M_XOR; op_cin = 1'b0;
        end
      end
      if (out_valid) begin
        r[nr] = res;
        c[nr] = res_cout;
        nr++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nr !== 2 || na !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d acc %0d res exp 2/2",
               na, nr);
    end else begin
      checks++;
      if (r[0] !== 16'h2203 || c[0] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_res0: got %h/%b exp 2203/1",
                 r[0], c[0]);
      end
      checks++;
      if (r[1] !== 16'h0000 || c[1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_res1: got %h/%b exp 0000/0",
                 r[1], c[1]);
      end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] !== N + 2) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d exp %0d",
                 acc_cyc[1] - acc_cyc[0], N + 2);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_eqv();
    test_xor_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
